instr_bank_ring: RTL and testbench

- N-bank generalisation of the instruction ping-pong store that sits between the host/testbench loader and control_top.
- The host fills instruction banks in round-robin order while the executor drains previously committed banks in the same order, so loading overlaps execution across up to N_IBANKS-1 banks.
- Per-bank ownership is tracked by a state machine. Each bank carries a committed length, so partial programs need no padding.
- With N_IBANKS=2 the block behaves as a ping-pong store, but bank selection is automatic rather than driven by an external select pin.

---
 rtl/instr_bank_ring_pkg.sv | 10 +
 rtl/instr_bank_ring_rd_pipe.sv | 32 +++
 rtl/my_memory.sv | 25 ++
 rtl/instr_bank_ring.sv | 176 +++++++++++++++++
 tb/tb_instr_bank_ring.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_bank_ring_pkg.sv
// Shared types and defaults for the round-robin instruction bank store.
package instr_bank_ring_pkg;
  localparam int INSTR_L          = 64;
  localparam int IBANK_N_DEF      = 4;
  localparam int IBANK_ADDR_W_DEF = 10;

  typedef enum logic [1:0] {EMPTY, FILLING, READY, EXEC} ibank_state_t;
  typedef logic [$clog2(IBANK_N_DEF)-1:0] ibank_id_t;
  typedef logic [IBANK_ADDR_W_DEF:0]      ibank_len_t;
endpackage

// File: rtl/instr_bank_ring_rd_pipe.sv
// Read-return tracker: shifts issue valid and {bank, offset} through RD_LATENCY stages.
module ibank_rd_pipe #(
  parameter int RD_LATENCY = 1,
  parameter int AW         = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [AW-1:0] issue_addr,
  output logic          ret_vld,
  output logic [AW-1:0] ret_addr
);
  logic [RD_LATENCY-1:0] vld_reg;
  logic [AW-1:0]         addr_reg [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
      for (int i = 0; i < RD_LATENCY; i++) addr_reg[i] <= '0;
    end else begin
      vld_reg[0]  <= issue;
      addr_reg[0] <= issue_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_reg[i]  <= vld_reg[i-1];
        addr_reg[i] <= addr_reg[i-1];
      end
    end
  end

  assign ret_vld  = vld_reg[RD_LATENCY-1];
  assign ret_addr = ret_vld ? addr_reg[RD_LATENCY-1] : '0;
endmodule

// File: rtl/my_memory.sv
// Simple dual-port block RAM: one write port, one read port with registered output.
module my_memory #(
  parameter int N_BANKS = 1,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 10,
  localparam int AW     = ADDR_W + $clog2(N_BANKS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/instr_bank_ring.sv
// N-bank instruction store: host fills banks round-robin while the executor drains
// committed banks in the same order; per-bank ownership is EMPTY/FILLING/READY/EXEC.
module instr_bank_ring
  import instr_bank_ring_pkg::*;
#(
  parameter int N_IBANKS   = IBANK_N_DEF,
  parameter int INSTR_W    = INSTR_L,
  parameter int ADDR_W     = IBANK_ADDR_W_DEF,
  parameter int RD_LATENCY = 1,
  localparam int IDW       = $clog2(N_IBANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_wr_en,
  input  logic [ADDR_W-1:0]     host_wr_addr,
  input  logic [INSTR_W-1:0]    host_wr_data,
  input  logic                  host_commit,
  input  logic [ADDR_W:0]       host_commit_len,
  output logic                  host_bank_avail,
  output logic [IDW-1:0]        host_fill_bank,
  output logic                  host_err,
  input  logic                  exec_enable,
  input  logic                  exec_rd_rdy,
  output logic [INSTR_W-1:0]    exec_instr,
  output logic                  exec_instr_vld,
  output logic [IDW+ADDR_W-1:0] exec_instr_addr,
  output logic                  exec_bank_done,
  output logic                  idle
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam int OW = $clog2(RD_LATENCY + 2);

  ibank_state_t    state_reg [N_IBANKS];
  ibank_state_t    state_next [N_IBANKS];
  logic [ADDR_W:0] len_reg [N_IBANKS];
  logic [ADDR_W:0] len_next [N_IBANKS];
  logic [IDW-1:0]  fill_ptr_reg, fill_ptr_next;
  logic [IDW-1:0]  exec_ptr_reg, exec_ptr_next;
  logic [ADDR_W:0] issue_off_reg, issue_off_next;
  logic [OW-1:0]   outstanding_reg, outstanding_next;
  logic [IDW-1:0]  rd_bank_reg;

  logic                  wr_ok, commit_ok, issue, ret_vld, bank_release;
  logic [IDW+ADDR_W-1:0] ret_addr;
  logic [INSTR_W-1:0]    mem_q [N_IBANKS];
  logic [INSTR_W-1:0]    ret_data;
  logic [N_IBANKS-1:0]   bank_empty;
  logic [N_IBANKS-1:0]   mem_we;

  assign host_bank_avail = (state_reg[fill_ptr_reg] == EMPTY) || (state_reg[fill_ptr_reg] == FILLING);
  assign host_fill_bank  = fill_ptr_reg;
  assign wr_ok           = host_wr_en && host_bank_avail;
  assign commit_ok       = host_commit && host_bank_avail &&
                           (host_commit_len != '0) && (host_commit_len <= MAX_LEN);
  assign host_err        = (host_wr_en && !host_bank_avail) || (host_commit && !commit_ok);

  assign issue = (state_reg[exec_ptr_reg] == EXEC) && exec_enable && exec_rd_rdy &&
                 (issue_off_reg < len_reg[exec_ptr_reg]);
  // Last return of a fully issued bank: the counter still includes this word.
  assign bank_release = ret_vld && (state_reg[exec_ptr_reg] == EXEC) &&
                        (issue_off_reg == len_reg[exec_ptr_reg]) && (outstanding_reg == OW'(1));

  always_comb begin
    for (int i = 0; i < N_IBANKS; i++) begin
      state_next[i] = state_reg[i];
      len_next[i]   = len_reg[i];
    end
    fill_ptr_next    = fill_ptr_reg;
    exec_ptr_next    = exec_ptr_reg;
    issue_off_next   = issue_off_reg;
    outstanding_next = outstanding_reg + OW'(issue) - OW'(ret_vld);

    if (wr_ok && state_reg[fill_ptr_reg] == EMPTY) state_next[fill_ptr_reg] = FILLING;
    if (commit_ok) begin
      state_next[fill_ptr_reg] = READY;
      len_next[fill_ptr_reg]   = host_commit_len;
      fill_ptr_next            = fill_ptr_reg + IDW'(1);
    end

    // Fill and exec pointers never own the same bank, so these updates never collide.
    case (state_reg[exec_ptr_reg])
      READY: begin
        if (exec_enable) begin
          state_next[exec_ptr_reg] = EXEC;
          issue_off_next           = '0;
        end
      end
      EXEC: begin
        if (issue) issue_off_next = issue_off_reg + (ADDR_W+1)'(1);
        if (bank_release) begin
          state_next[exec_ptr_reg] = EMPTY;
          exec_ptr_next            = exec_ptr_reg + IDW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IBANKS; i++) begin
        state_reg[i] <= EMPTY;
        len_reg[i]   <= '0;
      end
      fill_ptr_reg    <= '0;
      exec_ptr_reg    <= '0;
      issue_off_reg   <= '0;
      outstanding_reg <= '0;
      rd_bank_reg     <= '0;
    end else begin
      for (int i = 0; i < N_IBANKS; i++) begin
        state_reg[i] <= state_next[i];
        len_reg[i]   <= len_next[i];
      end
      fill_ptr_reg    <= fill_ptr_next;
      exec_ptr_reg    <= exec_ptr_next;
      issue_off_reg   <= issue_off_next;
      outstanding_reg <= outstanding_next;
      if (issue) rd_bank_reg <= exec_ptr_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_IBANKS; gi++) begin : g_bank
      assign mem_we[gi]     = wr_ok && (fill_ptr_reg == IDW'(gi));
      assign bank_empty[gi] = (state_reg[gi] == EMPTY);

      my_memory #(
        .N_BANKS (1),
        .DATA_W  (INSTR_W),
        .ADDR_W  (ADDR_W)
      ) u_mem (
        .clk   (clk),
        .we    (mem_we[gi]),
        .waddr (host_wr_addr),
        .wdata (host_wr_data),
        .re    (issue && (exec_ptr_reg == IDW'(gi))),
        .raddr (issue_off_reg[ADDR_W-1:0]),
        .rdata (mem_q[gi])
      );

      a_no_wr_owned: assert property (@(posedge clk) disable iff (rst)
        !(mem_we[gi] && (state_reg[gi] == READY || state_reg[gi] == EXEC)));
    end

    // The RAM supplies one cycle of latency; extra cycles are added here.
    if (RD_LATENCY > 1) begin : g_dly
      logic [INSTR_W-1:0] dly_reg [RD_LATENCY-1];
      always_ff @(posedge clk) begin
        dly_reg[0] <= mem_q[rd_bank_reg];
        for (int i = 1; i < RD_LATENCY-1; i++) dly_reg[i] <= dly_reg[i-1];
      end
      assign ret_data = dly_reg[RD_LATENCY-2];
    end else begin : g_nodly
      assign ret_data = mem_q[rd_bank_reg];
    end
  endgenerate

  ibank_rd_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .AW         (IDW + ADDR_W)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issue_addr ({exec_ptr_reg, issue_off_reg[ADDR_W-1:0]}),
    .ret_vld    (ret_vld),
    .ret_addr   (ret_addr)
  );

  assign exec_instr_vld  = ret_vld;
  assign exec_instr_addr = ret_addr;
  assign exec_instr      = ret_vld ? ret_data : '0;
  assign exec_bank_done  = bank_release;
  assign idle            = (&bank_empty) && (outstanding_reg == '0);
endmodule

// File: tb/tb_instr_bank_ring.sv
// Directed bench for instr_bank_ring (4 banks, depth 16, read latency 2).
module tb_instr_bank_ring;
  localparam int NB = 4, IW = 64, AW = 4, RL = 2, IDW = 2;

  logic clk = 1'b0;
  logic rst, host_wr_en, host_commit, exec_enable, exec_rd_rdy;
  logic [AW-1:0]     host_wr_addr;
  logic [IW-1:0]     host_wr_data;
  logic [AW:0]       host_commit_len;
  logic              host_bank_avail, host_err, exec_instr_vld, exec_bank_done, idle;
  logic [IDW-1:0]    host_fill_bank;
  logic [IW-1:0]     exec_instr;
  logic [IDW+AW-1:0] exec_instr_addr;

  int n_cmp = 0, n_bad = 0, cyc = 0, err_cnt = 0;

  typedef struct {
    int                c;
    logic [IDW+AW-1:0] a;
    logic [IW-1:0]     d;
  } ret_t;
  ret_t ret_q[$];
  int   done_q[$];

  instr_bank_ring #(
    .N_IBANKS (NB), .INSTR_W (IW), .ADDR_W (AW), .RD_LATENCY (RL)
  ) dut (
    .clk (clk), .rst (rst),
    .host_wr_en (host_wr_en), .host_wr_addr (host_wr_addr), .host_wr_data (host_wr_data),
    .host_commit (host_commit), .host_commit_len (host_commit_len),
    .host_bank_avail (host_bank_avail), .host_fill_bank (host_fill_bank), .host_err (host_err),
    .exec_enable (exec_enable), .exec_rd_rdy (exec_rd_rdy),
    .exec_instr (exec_instr), .exec_instr_vld (exec_instr_vld), .exec_instr_addr (exec_instr_addr),
    .exec_bank_done (exec_bank_done), .idle (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exec_instr_vld) ret_q.push_back('{c: cyc, a: exec_instr_addr, d: exec_instr});
    if (exec_bank_done) done_q.push_back(cyc);
    if (host_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [IW-1:0] d,
                         input logic cm, input logic [AW:0] len, output logic err);
    host_wr_en = we; host_wr_addr = a; host_wr_data = d;
    host_commit = cm; host_commit_len = len;
    @(negedge clk);
    err = host_err;
    step();
    host_wr_en = 1'b0; host_commit = 1'b0;
  endtask

  task automatic chk_ret(input string tag, input int idx, input int base, input int t0,
                         input int ec, input logic [IDW+AW-1:0] ea, input logic [IW-1:0] ed);
    if (base + idx < ret_q.size()) begin
      chk({tag, "_cyc"},  64'(ret_q[base+idx].c - t0), 64'(ec));
      chk({tag, "_addr"}, 64'(ret_q[base+idx].a), 64'(ea));
      chk({tag, "_data"}, ret_q[base+idx].d, ed);
    end else begin
      chk({tag, "_missing"}, 64'(ret_q.size()), 64'(base + idx + 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; exec_enable = 1'b0; exec_rd_rdy = 1'b0;
    host_wr_en = 1'b0; host_commit = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    logic e;
    int t0, lb, db, eb;
    logic [15:0] rdy_pat;

    rst = 1'b0; host_wr_en = 1'b0; host_commit = 1'b0; host_wr_addr = '0;
    host_wr_data = '0; host_commit_len = '0; exec_enable = 1'b0; exec_rd_rdy = 1'b0;

    // Reset state
    do_reset();
    chk("rst_avail", 64'(host_bank_avail), 64'(1));
    chk("rst_fill",  64'(host_fill_bank), 64'(0));
    chk("rst_err",   64'(host_err), 64'(0));
    chk("rst_vld",   64'(exec_instr_vld), 64'(0));
    chk("rst_instr", exec_instr, 64'(0));
    chk("rst_done",  64'(exec_bank_done), 64'(0));
    chk("rst_idle",  64'(idle), 64'(1));

    // T1: three words into bank0, drain in order
    host_op(1, 0, 64'hAAAA_0000_0000_000A, 0, 0, e);
    host_op(1, 1, 64'hBBBB_0000_0000_000B, 0, 0, e);
    host_op(1, 2, 64'hCCCC_0000_0000_000C, 0, 0, e);
    host_op(0, 0, 0, 1, 3, e);
    chk("t1_commit_err", 64'(e), 64'(0));
    chk("t1_fill", 64'(host_fill_bank), 64'(1));
    chk("t1_busy", 64'(idle), 64'(0));
    lb = ret_q.size(); db = done_q.size(); t0 = cyc;
    exec_enable = 1'b1; exec_rd_rdy = 1'b1;
    repeat (8) step();
    chk("t1_nret", 64'(ret_q.size() - lb), 64'(3));
    chk_ret("t1_r0", 0, lb, t0, 3, 6'h00, 64'hAAAA_0000_0000_000A);
    chk_ret("t1_r1", 1, lb, t0, 4, 6'h01, 64'hBBBB_0000_0000_000B);
    chk_ret("t1_r2", 2, lb, t0, 5, 6'h02, 64'hCCCC_0000_0000_000C);
    chk("t1_ndone", 64'(done_q.size() - db), 64'(1));
    if (done_q.size() > db) chk("t1_done_cyc", 64'(done_q[db] - t0), 64'(5));
    chk("t1_idle", 64'(idle), 64'(1));

    // T2: fill all four banks, dropped write, bank0 release frees fill slot
    do_reset();
    for (int b = 0; b < NB; b++) begin
      host_op(1, 0, 64'h1000 + 64'(b * 16), 0, 0, e);
      host_op(1, 1, 64'h1001 + 64'(b * 16), 0, 0, e);
      host_op(0, 0, 0, 1, 2, e);
    end
    chk("t2_full_avail", 64'(host_bank_avail), 64'(0));
    chk("t2_full_fill",  64'(host_fill_bank), 64'(0));
    eb = err_cnt;
    host_op(1, 0, 64'hDEAD_BEEF, 0, 0, e);
    chk("t2_drop_err", 64'(e), 64'(1));
    chk("t2_err_pulses", 64'(err_cnt - eb), 64'(1));
    lb = ret_q.size(); t0 = cyc;
    exec_enable = 1'b1; exec_rd_rdy = 1'b1;
    repeat (4) step();
    chk("t2_rel_done",  64'(exec_bank_done), 64'(1));
    chk("t2_rel_avail", 64'(host_bank_avail), 64'(0));
    step();
    chk("t2_after_avail", 64'(host_bank_avail), 64'(1));
    chk("t2_after_fill",  64'(host_fill_bank), 64'(0));
    chk_ret("t2_b0w0", 0, lb, t0, 3, 6'h00, 64'h1000);

    // T3: exec_rd_rdy toggling with latency 2
    do_reset();
    for (int i = 0; i < 4; i++) host_op(1, AW'(i), 64'h3300 + 64'(i), 0, 0, e);
    host_op(0, 0, 0, 1, 4, e);
    lb = ret_q.size(); db = done_q.size(); t0 = cyc;
    rdy_pat = 16'b1111_1111_1110_1010;
    exec_enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exec_rd_rdy = rdy_pat[k];
      step();
    end
    chk("t3_nret", 64'(ret_q.size() - lb), 64'(4));
    chk_ret("t3_r0", 0, lb, t0, 3, 6'h00, 64'h3300);
    chk_ret("t3_r1", 1, lb, t0, 5, 6'h01, 64'h3301);
    chk_ret("t3_r2", 2, lb, t0, 7, 6'h02, 64'h3302);
    chk_ret("t3_r3", 3, lb, t0, 8, 6'h03, 64'h3303);
    if (done_q.size() > db) chk("t3_done_cyc", 64'(done_q[db] - t0), 64'(8));
    else chk("t3_done_missing", 64'(done_q.size()), 64'(db + 1));

    // T4: illegal commit lengths leave the fill bank untouched
    do_reset();
    host_op(1, 0, 64'h4444_0000, 0, 0, e);
    host_op(0, 0, 0, 1, 0, e);
    chk("t4_len0_err",  64'(e), 64'(1));
    chk("t4_len0_fill", 64'(host_fill_bank), 64'(0));
    chk("t4_len0_avail", 64'(host_bank_avail), 64'(1));
    host_op(0, 0, 0, 1, 17, e);
    chk("t4_len17_err",  64'(e), 64'(1));
    chk("t4_len17_fill", 64'(host_fill_bank), 64'(0));
    host_op(0, 0, 0, 1, 1, e);
    chk("t4_len1_err",  64'(e), 64'(0));
    chk("t4_len1_fill", 64'(host_fill_bank), 64'(1));
    host_op(0, 0, 0, 1, 16, e);
    chk("t4_len16_err",  64'(e), 64'(0));
    chk("t4_len16_fill", 64'(host_fill_bank), 64'(2));
    lb = ret_q.size(); t0 = cyc;
    exec_enable = 1'b1; exec_rd_rdy = 1'b1;
    repeat (4) step();
    chk_ret("t4_r0", 0, lb, t0, 3, 6'h00, 64'h4444_0000);

    // T5: reset with two reads in flight
    do_reset();
    for (int i = 0; i < 3; i++) host_op(1, AW'(i), 64'h5500 + 64'(i), 0, 0, e);
    host_op(0, 0, 0, 1, 3, e);
    exec_enable = 1'b1; exec_rd_rdy = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    lb = ret_q.size();
    chk("t5_vld",   64'(exec_instr_vld), 64'(0));
    chk("t5_idle",  64'(idle), 64'(1));
    chk("t5_fill",  64'(host_fill_bank), 64'(0));
    chk("t5_avail", 64'(host_bank_avail), 64'(1));
    repeat (5) step();
    chk("t5_no_ret", 64'(ret_q.size() - lb), 64'(0));

    // T6: overlap fill and execution across a bank release
    do_reset();
    host_op(1, 0, 64'h6000, 0, 0, e);
    host_op(1, 1, 64'h6001, 0, 0, e);
    host_op(0, 0, 0, 1, 2, e);
    lb = ret_q.size(); db = done_q.size(); eb = err_cnt; t0 = cyc;
    exec_enable = 1'b1; exec_rd_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      host_wr_en = 1'b0; host_commit = 1'b0;
      case (k)
        2: begin
          host_wr_en = 1'b1; host_wr_addr = 0; host_wr_data = 64'h6100;
          host_commit = 1'b1; host_commit_len = 1;
        end
        4: begin
          host_wr_en = 1'b1; host_wr_addr = 0; host_wr_data = 64'h6200;
          @(negedge clk);
          chk("t6_rel_same_cyc", 64'(exec_bank_done), 64'(1));
        end
        5: begin host_commit = 1'b1; host_commit_len = 1; end
        default: ;
      endcase
      step();
    end
    host_wr_en = 1'b0; host_commit = 1'b0;
    chk_ret("t6_b0w0", 0, lb, t0, 3,  6'h00, 64'h6000);
    chk_ret("t6_b0w1", 1, lb, t0, 4,  6'h01, 64'h6001);
    chk_ret("t6_b1w0", 2, lb, t0, 8,  6'h10, 64'h6100);
    chk_ret("t6_b2w0", 3, lb, t0, 12, 6'h20, 64'h6200);
    chk("t6_ndone", 64'(done_q.size() - db), 64'(3));
    chk("t6_no_err", 64'(err_cnt - eb), 64'(0));
    chk("t6_idle", 64'(idle), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
